// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY
  } tx_state_e;

  // Header byte carries the payload length above the destination address.
  function automatic logic [DATA_W-1:0] mk_header(input logic [LEN_W-1:0]  len,
                                                  input logic [ADDR_W-1:0] dest);
    return {len, dest};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: synchronous-write, asynchronous-read byte array with
// write count, read pointer, full flag and a one-cycle clear.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_inc,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [LEN_W-1:0]  o_count,
  output logic [LEN_W-1:0]  o_rptr,
  output logic              o_full
);

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  logic [DATA_W-1:0] r_mem [MAX_LEN];
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_rptr;
  logic              r_full;
  logic              w_wr;

  // Writes at full are dropped without touching the count.
  assign w_wr = i_wr_en && !r_full && !i_clr;

  always_ff @(posedge i_clock) begin
    if (w_wr) r_mem[r_cnt] <= i_wr_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_wr) begin
        r_cnt  <= r_cnt + 1'b1;
        r_full <= ((r_cnt + 1'b1) == MAX_CNT);
      end
      if (i_rd_inc) r_rptr <= r_rptr + 1'b1;
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_cnt;
  assign o_rptr    = r_rptr;
  assign o_full    = r_full;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then sends header, payload
// and parity beats, stalling on busy. ROUTER_TX_PARITY_INJ_EN adds inject_err.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest,
  input  logic              busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
  input  logic              inject_err,
`endif
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_in,
  output logic              tx_idle,
  output logic              done,
  output logic              err,
  output logic              wr_full
);

  tx_state_e         r_state, w_state_nx;
  logic              r_pkt_valid, w_pkt_valid_nx;
  logic [DATA_W-1:0] r_data_in, w_data_in_nx;
  logic              r_done, w_done_nx;
  logic              r_err, w_err_nx;
  logic              r_tx_idle;
  logic [ADDR_W-1:0] r_dest, w_dest_nx;
  logic [LEN_W-1:0]  r_len, w_len_nx;
  logic [DATA_W-1:0] r_par, w_par_nx;
  logic              r_inj, w_inj_nx;

  logic              w_wr_en, w_rd_inc, w_clr, w_full;
  logic [DATA_W-1:0] w_rd_data;
  logic [LEN_W-1:0]  w_count, w_rptr, w_len_eff;
  logic [DATA_W-1:0] w_hdr;

  router_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_wr_en  (w_wr_en),
    .i_wr_data(wr_data),
    .i_rd_inc (w_rd_inc),
    .i_clr    (w_clr),
    .o_rd_data(w_rd_data),
    .o_count  (w_count),
    .o_rptr   (w_rptr),
    .o_full   (w_full)
  );

  // A write in the same cycle as start is counted into the packet length.
  assign w_len_eff = w_count + LEN_W'(wr_en && !w_full);
  assign w_hdr     = mk_header(w_len_eff, dest);

  always_comb begin
    w_state_nx     = r_state;
    w_pkt_valid_nx = r_pkt_valid;
    w_data_in_nx   = r_data_in;
    w_done_nx      = 1'b0;
    w_err_nx       = 1'b0;
    w_dest_nx      = r_dest;
    w_len_nx       = r_len;
    w_par_nx       = r_par;
    w_inj_nx       = r_inj;
    w_wr_en        = 1'b0;
    w_rd_inc       = 1'b0;
    w_clr          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wr_en = wr_en;
        if (start) begin
          if (w_len_eff == '0 || dest == ADDR_ILLEGAL) begin
            w_err_nx = 1'b1;
          end else begin
            w_dest_nx      = dest;
            w_len_nx       = w_len_eff;
            w_pkt_valid_nx = 1'b1;
            w_data_in_nx   = w_hdr;
            w_par_nx       = w_hdr;
            w_state_nx     = ST_HEADER;
`ifdef ROUTER_TX_PARITY_INJ_EN
            w_inj_nx       = inject_err;
`else
            w_inj_nx       = 1'b0;
`endif
          end
        end
      end
      ST_HEADER, ST_PAYLOAD: begin
        if (!busy) begin
          if (r_state == ST_PAYLOAD && w_rptr == r_len) begin
            w_pkt_valid_nx = 1'b0;
            w_data_in_nx   = r_par ^ {{(DATA_W-1){1'b0}}, r_inj};
            w_state_nx     = ST_PARITY;
          end else begin
            w_data_in_nx   = w_rd_data;
            w_par_nx       = r_par ^ w_rd_data;
            w_rd_inc       = 1'b1;
            w_state_nx     = ST_PAYLOAD;
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          w_data_in_nx = '0;
          w_done_nx    = 1'b1;
          w_clr        = 1'b1;
          w_state_nx   = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pkt_valid <= 1'b0;
      r_data_in   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tx_idle   <= 1'b1;
      r_dest      <= '0;
      r_len       <= '0;
      r_par       <= '0;
      r_inj       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pkt_valid <= w_pkt_valid_nx;
      r_data_in   <= w_data_in_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      r_tx_idle   <= (w_state_nx == ST_IDLE);
      r_dest      <= w_dest_nx;
      r_len       <= w_len_nx;
      r_par       <= w_par_nx;
      r_inj       <= w_inj_nx;
    end
  end

  assign pkt_valid = r_pkt_valid;
  assign data_in   = r_data_in;
  assign tx_idle   = r_tx_idle;
  assign done      = r_done;
  assign err       = r_err;
  assign wr_full   = w_full;

endmodule
